uart_cmd_parser: RTL and testbench

Byte-level command engine directly downstream of the UART top. It pops received bytes from the RX FIFO, assembles fixed 5-byte frames, validates them, and performs one register read or write on a simple internal bus. It then pushes an ACK/NAK response, plus the read data on a successful read, into the TX FIFO. It is the host-control path from PC to on-chip registers.

---
 rtl/uart_cmd_pkg.sv | 31 +++
 rtl/uart_cmd_parser.sv | 160 ++++++++++++++++
 tb/tb_uart_cmd_parser.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command parser: FSM states,
// command codes, default framing bytes and the frame checksum.
package uart_cmd_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DATA,
        S_CHK,
        S_EXEC,
        S_RD_WAIT,
        S_TX_ACK,
        S_TX_NAK,
        S_TX_DATA
    } state_t;

    localparam logic [7:0] CMD_WR   = 8'h01;
    localparam logic [7:0] CMD_RD   = 8'h02;

    localparam logic [7:0] SYNC_DEF = 8'h55;
    localparam logic [7:0] ACK_DEF  = 8'h06;
    localparam logic [7:0] NAK_DEF  = 8'h15;

    function automatic logic [7:0] frame_chk(input logic [7:0] cmd,
                                             input logic [7:0] addr,
                                             input logic [7:0] data);
        return cmd ^ addr ^ data;
    endfunction

endpackage

// File: rtl/uart_cmd_parser.sv
// Host command engine: assembles 5-byte frames from the RX FIFO, performs one
// register read or write, and answers with ACK/NAK (+ read data) into the TX FIFO.
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE   = SYNC_DEF,
    parameter logic [7:0]  ACK_BYTE    = ACK_DEF,
    parameter logic [7:0]  NAK_BYTE    = NAK_DEF,
    parameter int unsigned TIMEOUT_CYC = 5_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_empty,
    input  logic [7:0] r_data,
    output logic       rd_uart,
    input  logic       tx_full,
    output logic [7:0] w_data,
    output logic       wr_uart,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       frame_err,
    output logic       busy
);

    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    state_t          state, state_nx;
    logic [7:0]      cmd_q, addr_q, data_q, chk_q, rdata_q;
    logic [TO_W-1:0] to_cnt;
    logic            to_hit;
    logic            in_frame;
    logic            cmd_ok;
    logic            frame_ok;
    logic            frame_ok_in;

    assign in_frame    = (state == S_CMD) || (state == S_ADDR) ||
                         (state == S_DATA) || (state == S_CHK);
    assign to_hit      = (to_cnt == TO_W'(TIMEOUT_CYC));
    assign cmd_ok      = (cmd_q == CMD_WR) || (cmd_q == CMD_RD);
    assign frame_ok    = cmd_ok && (chk_q == frame_chk(cmd_q, addr_q, data_q));
    // Validity of the frame as the CHK byte is being popped, so the bus
    // registers are already correct when EXEC strobes reg_we/reg_re.
    assign frame_ok_in = cmd_ok && (r_data == frame_chk(cmd_q, addr_q, data_q));
    assign busy        = (state != S_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            cmd_q     <= 8'h00;
            addr_q    <= 8'h00;
            data_q    <= 8'h00;
            chk_q     <= 8'h00;
            rdata_q   <= 8'h00;
            reg_addr  <= 8'h00;
            reg_wdata <= 8'h00;
            to_cnt    <= '0;
        end else begin
            state <= state_nx;

            if (rd_uart) begin
                case (state)
                    S_CMD:   cmd_q  <= r_data;
                    S_ADDR:  addr_q <= r_data;
                    S_DATA:  data_q <= r_data;
                    S_CHK: begin
                        chk_q <= r_data;
                        if (frame_ok_in) begin
                            reg_addr <= addr_q;
                            if (cmd_q == CMD_WR)
                                reg_wdata <= data_q;
                        end
                    end
                    default: ;
                endcase
            end

            if (state == S_RD_WAIT)
                rdata_q <= reg_rdata;

            if (in_frame && !rd_uart && !to_hit)
                to_cnt <= to_cnt + TO_W'(1);
            else
                to_cnt <= '0;
        end
    end

    always_comb begin
        state_nx  = state;
        rd_uart   = 1'b0;
        wr_uart   = 1'b0;
        w_data    = 8'h00;
        reg_we    = 1'b0;
        reg_re    = 1'b0;
        frame_err = 1'b0;

        case (state)
            S_IDLE: begin
                if (!rx_empty) begin
                    rd_uart = 1'b1;
                    if (r_data == SYNC_BYTE)
                        state_nx = S_CMD;
                end
            end
            S_CMD, S_ADDR, S_DATA, S_CHK: begin
                // Timeout wins over a byte arriving in the same cycle; that byte stays queued.
                if (to_hit) begin
                    frame_err = 1'b1;
                    state_nx  = S_IDLE;
                end else if (!rx_empty) begin
                    rd_uart = 1'b1;
                    case (state)
                        S_CMD:   state_nx = S_ADDR;
                        S_ADDR:  state_nx = S_DATA;
                        S_DATA:  state_nx = S_CHK;
                        default: state_nx = S_EXEC;
                    endcase
                end
            end
            S_EXEC: begin
                if (!frame_ok) begin
                    frame_err = 1'b1;
                    state_nx  = S_TX_NAK;
                end else if (cmd_q == CMD_WR) begin
                    reg_we   = 1'b1;
                    state_nx = S_TX_ACK;
                end else begin
                    reg_re   = 1'b1;
                    state_nx = S_RD_WAIT;
                end
            end
            S_RD_WAIT: state_nx = S_TX_ACK;
            S_TX_ACK: begin
                w_data = ACK_BYTE;
                if (!tx_full) begin
                    wr_uart  = 1'b1;
                    state_nx = (cmd_q == CMD_RD) ? S_TX_DATA : S_IDLE;
                end
            end
            S_TX_NAK: begin
                w_data = NAK_BYTE;
                if (!tx_full) begin
                    wr_uart  = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            S_TX_DATA: begin
                w_data = rdata_q;
                if (!tx_full) begin
                    wr_uart  = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser: behavioural RX/TX FIFOs around the DUT, a frame
// vector table plus hand-written back-pressure, timeout and reset sequences.
module tb_uart_cmd_parser;

    localparam int TO_CYC = 40;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_empty = 1'b1;
    logic [7:0] r_data = 8'h00;
    logic       rd_uart;
    logic       tx_full = 1'b0;
    logic [7:0] w_data;
    logic       wr_uart;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata = 8'hEE;
    logic       frame_err;
    logic       busy;

    uart_cmd_parser #(.TIMEOUT_CYC(TO_CYC)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_empty  (rx_empty),
        .r_data    (r_data),
        .rd_uart   (rd_uart),
        .tx_full   (tx_full),
        .w_data    (w_data),
        .wr_uart   (wr_uart),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_re    (reg_re),
        .reg_rdata (reg_rdata),
        .frame_err (frame_err),
        .busy      (busy)
    );

    initial forever #5 clk = ~clk;

    logic [7:0] rxq[$];
    logic [7:0] txq[$];
    logic [7:0] rd_val = 8'h00;
    logic       re_seen = 1'b0;
    int cyc = 0, last_pop = 0, first_tx = 0;
    int n_we = 0, n_re = 0, n_err = 0, bad_pop = 0, bad_wr = 0;
    logic [7:0] we_addr = 8'h00, we_data = 8'h00, re_addr = 8'h00;
    int total = 0, passed = 0;

    // FIFO models: inputs change on the falling edge, outputs are sampled 3 time units later.
    always @(negedge clk) begin
        rx_empty  = (rxq.size() == 0);
        r_data    = rx_empty ? 8'h00 : rxq[0];
        reg_rdata = re_seen ? rd_val : 8'hEE;
        re_seen   = 1'b0;
        #3;
        cyc++;
        if (rd_uart) begin
            if (rx_empty) bad_pop++;
            else begin
                void'(rxq.pop_front());
                last_pop = cyc;
            end
        end
        if (wr_uart) begin
            if (tx_full) bad_wr++;
            if (txq.size() == 0) first_tx = cyc;
            txq.push_back(w_data);
        end
        if (reg_we) begin
            n_we++;
            we_addr = reg_addr;
            we_data = reg_wdata;
        end
        if (reg_re) begin
            n_re++;
            re_addr = reg_addr;
            re_seen = 1'b1;
        end
        if (frame_err) n_err++;
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    task automatic clear_log();
        txq.delete();
        n_we = 0; n_re = 0; n_err = 0;
        last_pop = 0; first_tx = 0;
    endtask

    task automatic wait_done(input string nm);
        int idle = 0;
        for (int i = 0; i < 300 && idle < 3; i++) begin
            @(posedge clk); #1;
            if (rxq.size() == 0 && !busy) idle++;
            else idle = 0;
        end
        chk({"done_", nm}, int'(idle >= 3), 1);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    function automatic int txb(input int i);
        return (txq.size() > i) ? int'(txq[i]) : -1;
    endfunction

    typedef struct {
        logic [0:6][7:0] b;
        int              n;
        logic [7:0]      rd;
        int              we;
        logic [7:0]      wa, wd;
        int              re;
        logic [7:0]      ra;
        int              err;
        int              ntx;
        logic [7:0]      tx0, tx1;
        int              lat;
        logic [7:0]      fa, fw;
    } vec_t;

    vec_t vecs[6];

    initial begin
        //          bytes                                           n  rd     we wa     wd     re ra     err ntx tx0    tx1    lat fa     fw
        vecs[0] = '{{8'h55,8'h01,8'h10,8'hAB,8'hBA,8'h00,8'h00}, 5, 8'h00, 1, 8'h10, 8'hAB, 0, 8'h00, 0, 1, 8'h06, 8'h00, 2, 8'h10, 8'hAB};
        vecs[1] = '{{8'h55,8'h02,8'h20,8'h00,8'h22,8'h00,8'h00}, 5, 8'h3C, 0, 8'h00, 8'h00, 1, 8'h20, 0, 2, 8'h06, 8'h3C, 3, 8'h20, 8'hAB};
        vecs[2] = '{{8'h55,8'h01,8'h10,8'hAB,8'h00,8'h00,8'h00}, 5, 8'h00, 0, 8'h00, 8'h00, 0, 8'h00, 1, 1, 8'h15, 8'h00, 2, 8'h20, 8'hAB};
        vecs[3] = '{{8'h55,8'h01,8'h33,8'h5A,8'h68,8'h00,8'h00}, 5, 8'h00, 1, 8'h33, 8'h5A, 0, 8'h00, 0, 1, 8'h06, 8'h00, 2, 8'h33, 8'h5A};
        vecs[4] = '{{8'h00,8'hFF,8'h55,8'h07,8'h00,8'h00,8'h07}, 7, 8'h00, 0, 8'h00, 8'h00, 0, 8'h00, 1, 1, 8'h15, 8'h00, 2, 8'h33, 8'h5A};
        vecs[5] = '{{8'h55,8'h02,8'h55,8'h00,8'h57,8'h00,8'h00}, 5, 8'hA5, 0, 8'h00, 8'h00, 1, 8'h55, 0, 2, 8'h06, 8'hA5, 3, 8'h55, 8'h5A};

        // Reset state
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_rd_uart", rd_uart, 0);
        chk("rst_wr_uart", wr_uart, 0);
        chk("rst_strobes", {reg_we, reg_re, frame_err}, 0);
        chk("rst_w_data", w_data, 8'h00);
        chk("rst_reg_addr", reg_addr, 8'h00);
        chk("rst_reg_wdata", reg_wdata, 8'h00);
        cycles(3);
        reset = 1'b0;
        cycles(2);

        // Frame table
        for (int v = 0; v < 6; v++) begin
            string tag;
            tag = $sformatf("v%0d", v);
            clear_log();
            rd_val = vecs[v].rd;
            for (int i = 0; i < vecs[v].n; i++) rxq.push_back(vecs[v].b[i]);
            wait_done(tag);
            chk({tag, "_n_we"}, n_we, vecs[v].we);
            if (vecs[v].we > 0) begin
                chk({tag, "_we_addr"}, we_addr, vecs[v].wa);
                chk({tag, "_we_data"}, we_data, vecs[v].wd);
            end
            chk({tag, "_n_re"}, n_re, vecs[v].re);
            if (vecs[v].re > 0) chk({tag, "_re_addr"}, re_addr, vecs[v].ra);
            chk({tag, "_n_err"}, n_err, vecs[v].err);
            chk({tag, "_n_tx"}, txq.size(), vecs[v].ntx);
            chk({tag, "_tx0"}, txb(0), vecs[v].tx0);
            if (vecs[v].ntx > 1) chk({tag, "_tx1"}, txb(1), vecs[v].tx1);
            chk({tag, "_tx_latency"}, first_tx - last_pop, vecs[v].lat);
            chk({tag, "_hold_addr"}, reg_addr, vecs[v].fa);
            chk({tag, "_hold_wdata"}, reg_wdata, vecs[v].fw);
        end

        // Back-pressure on a read response, including a stall between ACK and data
        clear_log();
        rd_val  = 8'h3C;
        tx_full = 1'b1;
        rxq.push_back(8'h55); rxq.push_back(8'h02); rxq.push_back(8'h20);
        rxq.push_back(8'h00); rxq.push_back(8'h22);
        cycles(25);
        chk("bp_no_tx_while_full", txq.size(), 0);
        chk("bp_busy_held", busy, 1);
        chk("bp_n_re", n_re, 1);
        tx_full = 1'b0;
        for (int i = 0; i < 20 && txq.size() == 0; i++) cycles(1);
        tx_full = 1'b1;
        cycles(6);
        chk("bp_ack_only", txq.size(), 1);
        chk("bp_ack", txb(0), 8'h06);
        tx_full = 1'b0;
        wait_done("bp");
        chk("bp_n_tx", txq.size(), 2);
        chk("bp_data", txb(1), 8'h3C);

        // Inter-byte timeout
        clear_log();
        rxq.push_back(8'h55); rxq.push_back(8'h01);
        for (int i = 0; i < 20 && rxq.size() != 0; i++) cycles(1);
        cycles(30);
        chk("to_not_early_busy", busy, 1);
        chk("to_not_early_err", n_err, 0);
        for (int i = 0; i < 40 && n_err == 0; i++) cycles(1);
        chk("to_err", n_err, 1);
        cycles(2);
        chk("to_busy_drops", busy, 0);
        chk("to_no_tx", txq.size(), 0);
        chk("to_no_we", n_we, 0);

        // Asynchronous reset mid-frame, then a clean frame
        clear_log();
        rxq.push_back(8'h55); rxq.push_back(8'h01); rxq.push_back(8'h10);
        for (int i = 0; i < 20 && rxq.size() != 0; i++) cycles(1);
        cycles(1);
        chk("mid_busy", busy, 1);
        #2 reset = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_reg_addr", reg_addr, 8'h00);
        chk("arst_reg_wdata", reg_wdata, 8'h00);
        chk("arst_tx", {wr_uart, w_data}, 0);
        cycles(2);
        reset = 1'b0;
        cycles(1);
        clear_log();
        rxq.push_back(8'h55); rxq.push_back(8'h01); rxq.push_back(8'h44);
        rxq.push_back(8'h12); rxq.push_back(8'h57);
        wait_done("post_rst");
        chk("post_rst_n_we", n_we, 1);
        chk("post_rst_addr", we_addr, 8'h44);
        chk("post_rst_data", we_data, 8'h12);
        chk("post_rst_tx", txb(0), 8'h06);
        chk("post_rst_err", n_err, 0);

        chk("no_pop_when_empty", bad_pop, 0);
        chk("no_push_when_full", bad_wr, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, passed %0d of %0d", passed, total);
        $fatal(1);
    end

endmodule
